// File: rtl/target_classifier_stream.sv
// Streaming colour classifier: per-class RGB box thresholds, two-stage pipeline
// with ready/valid back-pressure, optional masking and per-frame hit statistics.
module target_classifier_stream #(
  parameter int PIX_W     = 4,
  parameter int N_CLASSES = 5,
  parameter int CNT_W     = 19,
  localparam int ID_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [ID_W-1:0]            cfg_class,
  input  logic [6*PIX_W-1:0]         cfg_data,
  input  logic                       mask_mode,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           red_in,
  input  logic [PIX_W-1:0]           green_in,
  input  logic [PIX_W-1:0]           blue_in,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  input  logic                       out_ready,
  output logic [2*PIX_W-1:0]         red_out,
  output logic [2*PIX_W-1:0]         green_out,
  output logic [2*PIX_W-1:0]         blue_out,
  output logic [N_CLASSES-1:0]       class_hit,
  output logic [ID_W-1:0]            class_id,
  output logic                       hit_any,
  output logic                       stat_valid,
  output logic [N_CLASSES*CNT_W-1:0] stat_count
);

  localparam int CFG_W = 6 * PIX_W;
  localparam logic [PIX_W-1:0] PIX_ONES = '1;
  localparam logic [PIX_W-1:0] PIX_ZERO = '0;
  // min > max on every channel disables the class
  localparam logic [CFG_W-1:0] THR_OFF =
    {PIX_ONES, PIX_ZERO, PIX_ONES, PIX_ZERO, PIX_ONES, PIX_ZERO};

  function automatic logic class_match(input logic [CFG_W-1:0] thr,
                                       input logic [PIX_W-1:0] r,
                                       input logic [PIX_W-1:0] g,
                                       input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] f [6];
    for (int i = 0; i < 6; i++) f[i] = thr[CFG_W-1-i*PIX_W -: PIX_W];
    return (r >= f[0]) && (r <= f[1]) && (g >= f[2]) && (g <= f[3]) &&
           (b >= f[4]) && (b <= f[5]);
  endfunction

  logic [CFG_W-1:0]     thr_q [N_CLASSES];
  logic                 en;
  logic                 cfg_hit;

  logic                 s1_valid_q, s1_sop_q, s1_eop_q, s1_mask_q;
  logic [PIX_W-1:0]     s1_r_q, s1_g_q, s1_b_q;
  logic [N_CLASSES-1:0] s1_hit_q, hit_d;

  logic                 out_valid_q, out_sop_q, out_eop_q;
  logic [2*PIX_W-1:0]   red_q, green_q, blue_q;
  logic [N_CLASSES-1:0] class_hit_q;
  logic [ID_W-1:0]      class_id_q, id_d;
  logic                 hit_any_q, any_d, pass_d;

  logic [CNT_W-1:0]     cnt_q [N_CLASSES];
  logic [CNT_W-1:0]     cnt_sum [N_CLASSES];
  logic [N_CLASSES*CNT_W-1:0] stat_count_q;
  logic                 stat_valid_q;
  logic                 hs;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign hs       = out_valid_q && out_ready;
  assign cfg_hit  = cfg_we && ({1'b0, cfg_class} < (ID_W+1)'(N_CLASSES));

  // NOTE: threshold registers must come out of reset disabled, so this small
  // register file is reset explicitly rather than left uninitialised like a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CLASSES; k++) thr_q[k] <= THR_OFF;
    end else if (cfg_hit) begin
      thr_q[cfg_class] <= cfg_data;
    end
  end

  // Compare against the thresholds as they stand before this edge's cfg write.
  always_comb begin
    for (int k = 0; k < N_CLASSES; k++)
      hit_d[k] = class_match(thr_q[k], red_in, green_in, blue_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_mask_q  <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_hit_q   <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the pre-edge value of its predecessor.
      s1_valid_q <= in_valid;
      s1_sop_q   <= in_valid && in_sop;
      s1_eop_q   <= in_valid && in_eop;
      if (in_valid) begin
        s1_mask_q <= mask_mode;
        s1_r_q    <= red_in;
        s1_g_q    <= green_in;
        s1_b_q    <= blue_in;
        s1_hit_q  <= hit_d;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    id_d = '0;
    for (int k = N_CLASSES - 1; k >= 0; k--)
      if (s1_hit_q[k]) id_d = ID_W'(k);
    any_d  = |s1_hit_q;
    pass_d = s1_mask_q || any_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      class_hit_q <= '0;
      class_id_q  <= '0;
      hit_any_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      out_sop_q   <= s1_valid_q && s1_sop_q;
      out_eop_q   <= s1_valid_q && s1_eop_q;
      if (s1_valid_q) begin
        red_q       <= pass_d ? {s1_r_q, s1_r_q} : '0;
        green_q     <= pass_d ? {s1_g_q, s1_g_q} : '0;
        blue_q      <= pass_d ? {s1_b_q, s1_b_q} : '0;
        class_hit_q <= s1_hit_q;
        class_id_q  <= id_d;
        hit_any_q   <= any_d;
      end
    end
  end

  // sop restarts the frame count with this pixel included; counts saturate.
  always_comb begin
    for (int k = 0; k < N_CLASSES; k++) begin
      cnt_sum[k] = out_sop_q ? CNT_W'(class_hit_q[k])
                 : (&cnt_q[k]) ? cnt_q[k]
                 : cnt_q[k] + CNT_W'(class_hit_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CLASSES; k++) cnt_q[k] <= '0;
      stat_count_q <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      stat_valid_q <= hs && out_eop_q;
      if (hs) begin
        for (int k = 0; k < N_CLASSES; k++) begin
          if (out_eop_q) begin
            stat_count_q[k*CNT_W +: CNT_W] <= cnt_sum[k];
            cnt_q[k] <= '0;
          end else begin
            cnt_q[k] <= cnt_sum[k];
          end
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign red_out    = red_q;
  assign green_out  = green_q;
  assign blue_out   = blue_q;
  assign class_hit  = class_hit_q;
  assign class_id   = class_id_q;
  assign hit_any    = hit_any_q;
  assign stat_valid = stat_valid_q;
  assign stat_count = stat_count_q;

endmodule

// File: tb/tb_target_classifier_stream.sv
// Directed bench for target_classifier_stream: scoreboard of expected pixels
// plus a frame-statistics model, checked with immediate assertions.
module tb_target_classifier_stream;

  localparam int PIX_W = 4;
  localparam int N     = 5;
  localparam int CNT_W = 3;
  localparam int ID_W  = 3;
  localparam logic [23:0] THR_OFF = 24'hF0F0F0;
  localparam logic [23:0] THR_ALL = 24'h0F0F0F;

  typedef struct packed {
    logic [7:0]   r, g, b;
    logic [N-1:0] hit;
    logic [2:0]   id;
    logic         any, sop, eop;
  } exp_t;

  logic clk = 0, rst = 1;
  logic cfg_we = 0;
  logic [ID_W-1:0] cfg_class = '0;
  logic [23:0] cfg_data = '0;
  logic mask_mode = 0;
  logic in_valid = 0, in_sop = 0, in_eop = 0, in_ready;
  logic [3:0] red_in = 0, green_in = 0, blue_in = 0;
  logic out_valid, out_sop, out_eop, out_ready = 0;
  logic [7:0] red_out, green_out, blue_out;
  logic [N-1:0] class_hit;
  logic [ID_W-1:0] class_id;
  logic hit_any, stat_valid;
  logic [N*CNT_W-1:0] stat_count;

  target_classifier_stream #(.PIX_W(PIX_W), .N_CLASSES(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_data(cfg_data),
    .mask_mode(mask_mode), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .class_hit(class_hit), .class_id(class_id), .hit_any(hit_any),
    .stat_valid(stat_valid), .stat_count(stat_count));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  exp_t sb[$];
  logic [23:0] m_thr [N];
  int m_cnt [N];
  logic m_pend = 0;
  logic [N*CNT_W-1:0] m_stat = '0;
  logic stall_prev = 0;
  exp_t held;
  logic last_acc = 0;
  logic pat_en = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int pat_i = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] r, g, b, input logic m, s, e);
    exp_t x;
    logic pass;
    x.hit = '0;
    for (int k = 0; k < N; k++)
      if (r >= m_thr[k][23:20] && r <= m_thr[k][19:16] && g >= m_thr[k][15:12] &&
          g <= m_thr[k][11:8] && b >= m_thr[k][7:4] && b <= m_thr[k][3:0])
        x.hit[k] = 1'b1;
    x.any = |x.hit;
    x.id = '0;
    for (int k = N - 1; k >= 0; k--) if (x.hit[k]) x.id = 3'(k);
    pass = m || x.any;
    x.r = pass ? {r, r} : 8'h00;
    x.g = pass ? {g, g} : 8'h00;
    x.b = pass ? {b, b} : 8'h00;
    x.sop = s;
    x.eop = e;
    return x;
  endfunction

  function automatic exp_t pack_out();
    return exp_t'({red_out, green_out, blue_out, class_hit, class_id, hit_any, out_sop, out_eop});
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int k = 0; k < N; k++) begin m_thr[k] = THR_OFF; m_cnt[k] = 0; end
    m_pend = 0;
    m_stat = '0;
    stall_prev = 0;
  endtask

  // One clock: sample at the falling edge, update the models, advance.
  task automatic step();
    exp_t e;
    logic nxt_pend, stall_now, was_rst;
    logic [N*CNT_W-1:0] nxt_stat;
    int v, base;
    if (pat_en) begin out_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
    @(negedge clk);
    was_rst = rst;
    nxt_pend = 0;
    nxt_stat = m_stat;
    stall_now = 0;
    last_acc = 0;
    if (!rst) begin
      chk("stat_valid", 64'(stat_valid), 64'(m_pend));
      chk("stat_count", 64'(stat_count), 64'(m_stat));
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(pack_out()), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("pixel", 64'(pack_out()), 64'(e));
          for (int k = 0; k < N; k++) begin
            base = e.sop ? 0 : m_cnt[k];
            v = base + int'(e.hit[k]);
            if (v > (1 << CNT_W) - 1) v = (1 << CNT_W) - 1;
            if (e.eop) begin
              nxt_stat[k*CNT_W +: CNT_W] = CNT_W'(v);
              m_cnt[k] = 0;
            end else begin
              m_cnt[k] = v;
            end
          end
          nxt_pend = e.eop;
        end
      end
      stall_now = out_valid && !out_ready;
      held = pack_out();
      if (in_valid && in_ready) begin
        sb.push_back(model(red_in, green_in, blue_in, mask_mode, in_sop, in_eop));
        last_acc = 1;
      end
      if (cfg_we && cfg_class < ID_W'(N)) m_thr[cfg_class] = cfg_data;
    end
    @(posedge clk);
    #1;
    m_pend = nxt_pend;
    m_stat = nxt_stat;
    stall_prev = stall_now;
    if (was_rst) model_reset();
  endtask

  task automatic cfg(input logic [ID_W-1:0] cls, input logic [23:0] data);
    cfg_we = 1; cfg_class = cls; cfg_data = data;
    step();
    cfg_we = 0;
  endtask

  task automatic send(input logic [3:0] r, g, b, input logic s, e);
    in_valid = 1; red_in = r; green_in = g; blue_in = b; in_sop = s; in_eop = e;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    rst = 1;
    idle(3);
    rst = 0;
    // Reset state, with out_ready low: in_ready must still be 1.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stat_valid", 64'(stat_valid), 64'd0);
    chk("rst_stat_count", 64'(stat_count), 64'd0);
    chk("rst_out_data", 64'(pack_out()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    out_ready = 1;
    cfg(0, {4'd8, 4'd15, 4'd2, 4'd5, 4'd0, 4'd5});
    send(12, 3, 1, 0, 0);
    chk("lat1_not_valid", 64'(out_valid), 64'd0);
    step();
    chk("lat2_valid", 64'(out_valid), 64'd1);
    chk("lat2_rgb", 64'({red_out, green_out, blue_out}), 64'h00CC3311);
    chk("lat2_class", 64'({class_hit, class_id, hit_any}), 64'({5'b00001, 3'd0, 1'b1}));
    idle(2);

    mask_mode = 0; send(1, 1, 1, 0, 0);
    mask_mode = 1; send(1, 1, 1, 0, 0);
    mask_mode = 0; idle(3);

    // Overlapping classes on a one-pixel frame.
    cfg(1, {4'd0, 4'd3, 4'd10, 4'd15, 4'd0, 4'd3});
    cfg(3, {4'd2, 4'd2, 4'd12, 4'd12, 4'd2, 4'd2});
    send(2, 12, 2, 1, 1);
    step();
    chk("multi_class", 64'({class_hit, class_id}), 64'({5'b01010, 3'd1}));
    idle(3);

    // Write on the same edge as a pixel: that pixel still sees the old class 2.
    cfg_we = 1; cfg_class = 2; cfg_data = THR_ALL;
    send(7, 7, 7, 0, 0);
    cfg_we = 0;
    send(7, 7, 7, 0, 0);
    cfg(1, THR_OFF); cfg(2, THR_OFF); cfg(3, THR_OFF);
    cfg(5, THR_ALL); cfg(7, THR_ALL);
    send(7, 7, 7, 0, 0);
    idle(3);

    // Back-pressure with out_ready cycling 1,0,0,1.
    pat_en = 1; pat_i = 0;
    for (int i = 0; i < 8; i++)
      send(4'(i * 3 + 1), 4'(i + 2), 4'(15 - i), 1'b0, 1'b0);
    idle(6);
    pat_en = 0; out_ready = 1;
    idle(3);

    // Ten-pixel frame with four class-0 hits, then a fresh three-pixel frame.
    for (int i = 0; i < 10; i++)
      if (i % 3 == 0) send(9, 3, 2, i == 0, i == 9);
      else send(1, 1, 1, i == 0, i == 9);
    idle(4);
    chk("frame_class0", 64'(stat_count[2:0]), 64'd4);
    chk("frame_others", 64'(stat_count[14:3]), 64'd0);
    for (int i = 0; i < 3; i++) send(10, 4, 3, i == 0, i == 2);
    idle(4);
    chk("frame2_class0", 64'(stat_count[2:0]), 64'd3);
    for (int i = 0; i < 10; i++) send(8, 2, 0, i == 0, i == 9);
    idle(4);
    chk("frame_saturate", 64'(stat_count[2:0]), 64'd7);

    // Reset in mid-frame, then reconfigure and count a clean frame.
    for (int i = 0; i < 5; i++) send(9, 3, 2, i == 0, 1'b0);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_stat_count", 64'(stat_count), 64'd0);
    send(12, 3, 1, 0, 0);
    idle(3);
    cfg(0, {4'd8, 4'd15, 4'd2, 4'd5, 4'd0, 4'd5});
    send(12, 3, 1, 1, 0);
    send(1, 1, 1, 0, 0);
    send(15, 5, 5, 0, 1);
    idle(4);
    chk("postrst_class0", 64'(stat_count[2:0]), 64'd2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
